// File: rtl/alu_seq.sv
// alu_seq: registered MIPS ALU with a valid/ready request port.
// Single-cycle ops answer the next cycle; MUL/MULH/DIV/REM iterate W cycles on magnitudes.
module alu_seq #(
    parameter int W      = 32,
    parameter bit MULDIV = 1'b1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    input  logic [W-1:0] iA,
    input  logic [W-1:0] iB,
    input  logic [5:0]   iALUFun,
    input  logic         iSign,
    input  logic         iFlush,
    output logic         oReady,
    output logic         oValid,
    output logic [W-1:0] oS,
    output logic         oZ,
    output logic         oV,
    output logic         oN
);
    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic           rdy, valid, z, v, n;
    logic           acc, iter_op, last;
    logic           neg_q, neg_r, dz, ovf;
    logic [1:0]     op;
    logic [SW-1:0]  cnt;
    logic [W-1:0]   s, d, ma, mb, q, r, alu_s, it_s;
    logic           alu_v, alu_n, it_v, sa, sd;
    logic [W:0]     usum, udif, msum, t;
    logic [2*W-1:0] p, p_nxt, prod;

    assign acc     = iValid && oReady && !iFlush;
    assign iter_op = MULDIV && iALUFun[5:2] == 4'b0001;
    assign last    = cnt == SW'(W - 1);
    assign ma      = (iSign && iA[W-1]) ? -iA : iA;
    assign mb      = (iSign && iB[W-1]) ? -iB : iB;

    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = iFlush ? IDLE :
                    state == BUSY ? (last ? DONE : BUSY) :
                    (acc && iter_op) ? BUSY : IDLE;
    end

    always_comb begin
        oReady = rdy && state != BUSY;
    end

    assign oValid = valid;
    assign oS     = s;
    assign oZ     = z;
    assign oV     = v;
    assign oN     = n;

    // sa/sd: sign of the true (W+1)-bit signed sum/difference, rebuilt from the unsigned carry/borrow
    always_comb begin
        usum  = {1'b0, iA} + {1'b0, iB};
        udif  = {1'b0, iA} - {1'b0, iB};
        sa    = iA[W-1] ^ iB[W-1] ^ usum[W];
        sd    = iA[W-1] ^ iB[W-1] ^ udif[W];
        alu_s = '0;
        alu_v = 1'b0;
        alu_n = 1'b0;
        case (iALUFun)
            6'b000000: begin
                alu_s = usum[W-1:0];
                alu_v = iSign ? sa ^ usum[W-1] : usum[W];
                alu_n = iSign && sa;
            end
            6'b000001: begin
                alu_s = udif[W-1:0];
                alu_v = iSign ? sd ^ udif[W-1] : udif[W];
                alu_n = iSign && sd;
            end
            6'b011000: alu_s = iA & iB;
            6'b011110: alu_s = iA | iB;
            6'b010110: alu_s = iA ^ iB;
            6'b010001: alu_s = ~(iA | iB);
            6'b011010: alu_s = iA;
            6'b100000: alu_s = iB << iA[SW-1:0];
            6'b100001: alu_s = iB >> iA[SW-1:0];
            6'b100011: alu_s = $signed(iB) >>> iA[SW-1:0];
            6'b110011: alu_s = W'(iA == iB);
            6'b110001: alu_s = W'(iA != iB);
            6'b110101: alu_s = W'(iSign ? sd : udif[W]);
            6'b111101: alu_s = W'(iA[W-1] || iA == '0);
            6'b111001: alu_s = W'(!iA[W-1]);
            6'b111111: alu_s = W'(!iA[W-1] && iA != '0);
            default: ;
        endcase
        if (iALUFun[5:4] == 2'b01 || iALUFun[5:4] == 2'b10) alu_n = alu_s[W-1];
    end

    // p holds {acc, multiplier} for multiply and {remainder, quotient} for restoring divide
    always_comb begin
        msum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, d} : '0);
        t     = p[2*W-1:W-1] - {1'b0, d};
        p_nxt = op[1] ? (t[W] ? {p[2*W-2:0], 1'b0} : {t[W-1:0], p[W-2:0], 1'b1})
                      : {msum, p[W-1:1]};
        prod  = neg_q ? -p_nxt : p_nxt;
        q     = dz ? '1 : neg_q ? -p_nxt[W-1:0] : p_nxt[W-1:0];
        r     = neg_r ? -p_nxt[2*W-1:W] : p_nxt[2*W-1:W];
        it_s  = op[1] ? (op[0] ? r : q) : (op[0] ? prod[2*W-1:W] : prod[W-1:0]);
        it_v  = op[1] && (dz || ovf);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdy   <= 1'b0;
            valid <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            z     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
        end else begin
            rdy   <= 1'b1;
            valid <= 1'b0;
            if (acc && !iter_op) begin
                s     <= alu_s;
                z     <= alu_s == '0;
                v     <= alu_v;
                n     <= alu_n;
                valid <= 1'b1;
            end
            if (acc && iter_op) begin
                cnt   <= '0;
                op    <= iALUFun[1:0];
                p     <= {{W{1'b0}}, iALUFun[1] ? ma : mb};
                d     <= iALUFun[1] ? mb : ma;
                neg_q <= iSign && (iA[W-1] ^ iB[W-1]);
                neg_r <= iSign && iA[W-1];
                dz    <= iB == '0;
                ovf   <= iSign && iA == {1'b1, {(W-1){1'b0}}} && &iB;
            end
            if (state == BUSY && !iFlush) begin
                p   <= p_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    s     <= it_s;
                    z     <= it_s == '0;
                    v     <= it_v;
                    n     <= it_s[W-1];
                    valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomised checks of alu_seq against a scoreboard of expected results.
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b011000, OR = 6'b011110;
    localparam logic [5:0] XOR = 6'b010110, NOR = 6'b010001, STA = 6'b011010, SLL = 6'b100000;
    localparam logic [5:0] SRL = 6'b100001, SRA = 6'b100011, EQ = 6'b110011, NEQ = 6'b110001;
    localparam logic [5:0] LT = 6'b110101, LEZ = 6'b111101, GEZ = 6'b111001, GTZ = 6'b111111;
    localparam logic [5:0] MUL = 6'b000100, MULH = 6'b000101, DIV = 6'b000110, REM = 6'b000111;

    typedef struct packed {
        logic [W-1:0] s;
        logic         z, v, n;
    } exp_t;

    logic         iClk = 1'b0;
    logic         iRst, iValid, iSign, iFlush;
    logic [W-1:0] iA, iB;
    logic [5:0]   iALUFun;
    logic         oReady, oValid, oZ, oV, oN;
    logic [W-1:0] oS;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [5:0] codes[16] = '{ADD, SUB, AND, OR, XOR, NOR, STA, SLL, SRL, SRA, EQ, NEQ, LT, LEZ, GEZ, GTZ};

    alu_seq #(.W(W), .MULDIV(1'b1)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iA(iA), .iB(iB), .iALUFun(iALUFun),
        .iSign(iSign), .iFlush(iFlush), .oReady(oReady), .oValid(oValid), .oS(oS),
        .oZ(oZ), .oV(oV), .oN(oN)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic v, input logic n);
        mk = {s, s == '0, v, n};
    endfunction

    // Reference model built on native 64-bit integer arithmetic
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        longint x, y, sa, rr;
        logic [63:0] pp;
        exp_t e;
        x  = sg ? longint'($signed(a)) : longint'(a);
        y  = sg ? longint'($signed(b)) : longint'(b);
        sa = longint'($signed(a));
        e  = '0;
        case (f)
            ADD, SUB: begin
                rr  = (f == SUB) ? x - y : x + y;
                e.s = rr[31:0];
                e.v = sg ? rr != longint'($signed(rr[31:0])) : rr != longint'(rr[31:0]);
                e.n = sg && rr < 0;
            end
            AND: e.s = a & b;
            OR:  e.s = a | b;
            XOR: e.s = a ^ b;
            NOR: e.s = ~(a | b);
            STA: e.s = a;
            SLL: e.s = b << a[4:0];
            SRL: e.s = b >> a[4:0];
            SRA: e.s = $signed(b) >>> a[4:0];
            EQ:  e.s = {31'b0, a == b};
            NEQ: e.s = {31'b0, a != b};
            LT:  e.s = {31'b0, x < y};
            LEZ: e.s = {31'b0, sa <= 0};
            GEZ: e.s = {31'b0, sa >= 0};
            GTZ: e.s = {31'b0, sa > 0};
            MUL, MULH: begin
                pp  = 64'(x * y);
                e.s = (f == MUL) ? pp[31:0] : pp[63:32];
                e.n = e.s[31];
            end
            DIV, REM: begin
                if (b == 0) begin
                    e.s = (f == REM) ? a : '1;
                    e.v = 1'b1;
                end else if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.s = (f == REM) ? '0 : a;
                    e.v = 1'b1;
                end else begin
                    rr  = (f == REM) ? x % y : x / y;
                    e.s = rr[31:0];
                end
                e.n = e.s[31];
            end
            default: ;
        endcase
        if (f inside {AND, OR, XOR, NOR, STA, SLL, SRL, SRA}) e.n = e.s[31];
        e.z = e.s == '0;
        return e;
    endfunction

    task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        iValid  = 1'b1;
        iALUFun = f;
        iA      = a;
        iB      = b;
        iSign   = sg;
    endtask

    task automatic op1(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input exp_t e);
        drive(f, a, b, sg);
        sb.push_back(e);
        tick;
        iValid = 1'b0;
        chk("single_valid", oValid, 1'b1);
        chk("single_ready", oReady, 1'b1);
    endtask

    task automatic opn(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input exp_t e);
        logic bad;
        drive(f, a, b, sg);
        sb.push_back(e);
        tick;
        iValid = 1'b0;
        bad = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (oReady !== 1'b0 || oValid !== 1'b0) bad = 1'b1;
            iA = $urandom;
            iB = $urandom;
            tick;
        end
        chk("busy_stall", bad, 1'b0);
        chk("iter_valid", oValid, 1'b1);
        chk("iter_ready", oReady, 1'b1);
    endtask

    always @(posedge iClk) begin
        #2;
        if (oValid) begin
            if (sb.size() == 0) chk("spurious_valid", oValid, 1'b0);
            else begin
                mon_e = sb.pop_front();
                chk("result_s", oS, mon_e.s);
                chk("result_zvn", {oZ, oV, oN}, {mon_e.z, mon_e.v, mon_e.n});
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic [5:0]   f;
        logic         sg;
        iRst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iA = '0; iB = '0; iALUFun = '0; iSign = 1'b0;
        repeat (2) tick;
        chk("reset_ready", oReady, 1'b0);
        chk("reset_valid", oValid, 1'b0);
        chk("reset_s", oS, '0);
        chk("reset_flags", {oZ, oV, oN}, 3'b000);
        iRst = 1'b0;
        tick;
        chk("release_ready", oReady, 1'b1);
        chk("release_valid", oValid, 1'b0);
        chk("release_s", oS, '0);
        chk("release_flags", {oZ, oV, oN}, 3'b000);

        op1(ADD, 32'h7FFFFFFF, 32'd1, 1'b1, mk(32'h80000000, 1'b1, 1'b0));
        op1(SUB, 32'd3, 32'd5, 1'b0, mk(32'hFFFFFFFE, 1'b1, 1'b0));
        op1(6'b111000, 32'd5, 32'd6, 1'b1, mk('0, 1'b0, 1'b0));
        op1(LT, 32'hFFFFFFFF, 32'd1, 1'b1, mk(32'd1, 1'b0, 1'b0));
        op1(LT, 32'hFFFFFFFF, 32'd1, 1'b0, mk(32'd0, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                a  = (k == 0) ? $urandom : $urandom_range(0, 2) - 1;
                b  = (k == 0) ? $urandom : $urandom_range(0, 2) - 1;
                sg = 1'($urandom_range(0, 1));
                op1(codes[i], a, b, sg, model(codes[i], a, b, sg));
            end
        end

        for (int i = 0; i < 8; i++) begin
            f  = {4'b0001, 2'(i)};
            a  = $urandom;
            b  = (i == 7) ? '0 : $urandom >> $urandom_range(0, 31);
            sg = (i >= 4);
            opn(f, a, b, sg, model(f, a, b, sg));
        end
        opn(MUL, -32'd3, 32'd7, 1'b1, mk(32'hFFFFFFEB, 1'b0, 1'b1));
        opn(MULH, -32'd3, 32'd7, 1'b1, mk(32'hFFFFFFFF, 1'b0, 1'b1));
        opn(DIV, -32'd7, 32'd2, 1'b1, mk(-32'd3, 1'b0, 1'b1));
        opn(REM, -32'd7, 32'd2, 1'b1, mk(-32'd1, 1'b0, 1'b1));
        opn(DIV, 32'd9, 32'd0, 1'b0, mk(32'hFFFFFFFF, 1'b1, 1'b1));
        opn(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, mk(32'h80000000, 1'b1, 1'b1));

        // flush in the result cycle only rejects the same-cycle request
        drive(ADD, 32'd1, 32'd1, 1'b0);
        iFlush = 1'b1;
        chk("flush_done_ready", oReady, 1'b1);
        tick;
        iFlush = 1'b0;
        iValid = 1'b0;
        chk("flush_done_reject", oValid, 1'b0);

        drive(DIV, 32'd100, 32'd3, 1'b0);
        tick;
        iValid = 1'b0;
        repeat (9) tick;
        iFlush = 1'b1;
        tick;
        iFlush = 1'b0;
        chk("flush_ready", oReady, 1'b1);
        chk("flush_valid", oValid, 1'b0);
        chk("flush_keep_s", oS, 32'h80000000);
        chk("flush_keep_flags", {oZ, oV, oN}, 3'b011);
        repeat (W + 4) tick;

        drive(ADD, 32'd2, 32'd2, 1'b0);
        iFlush = 1'b1;
        tick;
        iFlush = 1'b0;
        iValid = 1'b0;
        chk("flush_idle_reject", oValid, 1'b0);
        chk("flush_idle_keep_s", oS, 32'h80000000);

        drive(DIV, 32'd100, 32'd3, 1'b0);
        tick;
        iValid = 1'b0;
        repeat (9) tick;
        iRst = 1'b1;
        tick;
        iRst = 1'b0;
        chk("abort_ready", oReady, 1'b0);
        chk("abort_valid", oValid, 1'b0);
        chk("abort_s", oS, '0);
        chk("abort_flags", {oZ, oV, oN}, 3'b000);
        tick;
        chk("abort_release_ready", oReady, 1'b1);
        repeat (W + 4) tick;

        op1(XOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, mk(32'hFFFFFFFF, 1'b0, 1'b1));
        repeat (3) tick;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the MIPS datapath with a valid/ready request interface. It supports the existing 6-bit ALUFun operation set and adds iterative multiply, divide and remainder. Single-cycle operations complete in one clock; multiply and divide operations take W+1 clocks. It sits in the EX stage and stalls the pipeline through `oReady` while an iterative operation is in flight.

## Interface
- `W`, 32: operand/result width, ≥ 8, power of two; shift-amount width `SW = clog2(W)`.
- `MULDIV`, 1: 1 = MUL/MULH/DIV/REM implemented; 0 = those codes behave as undefined.
- `iClk` input 1: clock; all state updates on the rising edge.
- `iRst` input 1: reset; synchronous and active-high.
- `iValid` input 1: request present; the request is accepted on a rising edge where `iValid & oReady & !iFlush`.
- `iA`, `iB` input W: operands, sampled only at accept.
- `iALUFun` input 6: operation code, sampled only at accept.
- `iSign` input 1: 1 = signed semantics, sampled only at accept.
- `iFlush` input 1: abort any in-flight iterative operation and discard any request in the same cycle.
- `oReady` output 1: block can accept a request this cycle.
- `oValid` output 1: one-cycle pulse; `oS`/`oZ`/`oV`/`oN` hold a new result.
- `oS` output W: result; held until the next result.
- `oZ`, `oV`, `oN` output 1: zero, overflow, negative flags; held with `oS`.

## Operation
- **Codes:**
  - ADD 000000, SUB 000001.
  - AND 011000, OR 011110, XOR 010110, NOR 010001, STA 011010 (`S = A`).
  - SLL 100000, SRL 100001, SRA 100011: shift `B` by `A[SW-1:0]`.
  - EQ 110011, NEQ 110001, LT 110101: `S = {W-1'b0, cond}`.
  - LEZ 111101, GEZ 111001, GTZ 111111: test `A` as signed, independent of `iSign`.
  - New: MUL 000100 (low W of product), MULH 000101 (high W of product), DIV 000110 (quotient), REM 000111 (remainder).
- **Undefined code:** `S=0, Z=1, V=0, N=0`, latency 1.
- **Z:** `oZ = (oS == 0)` for every defined code.
- **ADD/SUB, signed** (`iSign=1`):
  - `V` = two's-complement overflow.
  - `N` = sign of the true (W+1)-bit result, so it is correct on overflow.
- **ADD/SUB, unsigned** (`iSign=0`):
  - ADD: `V` = carry out.
  - SUB: `V` = borrow.
  - `N = 0`.
- **LT:** signed compare if `iSign=1`, else unsigned; `V=0, N=0`.
- **Logic/shift ops:** `V=0`, `N = S[W-1]`.
- **Compare ops:** `V=0, N=0`.
- **MUL/MULH:**
  - Radix-2 shift-add over W iterations on operand magnitudes.
  - If `iSign=1` and the operand signs differ, the 2W-bit product is negated in the final cycle.
  - `V=0`, `N = S[W-1]`.
- **DIV/REM:**
  - Restoring division over W iterations on magnitudes.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend `iA`.
  - `N = S[W-1]`.
  - Divide by zero: quotient = all ones, remainder = `iA`, `V=1`.
  - Signed `MIN / -1`: quotient = MIN, remainder = 0, `V=1`.
  - Otherwise `V=0`.
- **FSM states:** IDLE, BUSY (iteration counter 0..W-1), DONE.
  - IDLE → BUSY on accept of MUL/MULH/DIV/REM.
  - BUSY → DONE when the counter reaches W-1.
  - DONE → IDLE after 1 cycle.
  - Single-cycle ops stay in IDLE; their result is registered at accept.
- **iFlush:** any state → IDLE at the next edge; no `oValid`; `oS`/flags keep their previous values.

## Timing
- **Reset** (`iRst=1` at an edge): `oReady=0`, `oValid=0`, `oS=0`, `oZ=0`, `oV=0`, `oN=0`, FSM=IDLE, counter=0.
  - `oReady=1` from the first cycle after the first edge with `iRst=0`.
  - Reset during BUSY aborts the operation with no `oValid`.
- **Single-cycle op accepted at edge 0:** `oValid=1` and result visible in cycle 1; `oReady` stays 1, giving back-to-back throughput of 1/cycle.
- **Iterative op accepted at edge 0:**
  - `oReady=0` in cycles 1..W.
  - `oValid=1`, result visible and `oReady=1` in cycle W+1.
  - A new request may be accepted in cycle W+1.
- `oValid` is never high two consecutive cycles for the same result.
- `iFlush` and `iValid` in the same cycle: flush wins and the request is not accepted; `oReady` is unaffected by `iFlush` in that cycle.
- `iFlush` in cycle W+1 (`oValid` high): the result is already delivered; the flush has no effect beyond rejecting a same-cycle request.
- Inputs are ignored when not accepted; a change of `iA`/`iB` during BUSY has no effect.

## Test plan
- **Reset release:** `iRst` 1→0 → `oReady=1` next cycle; all outputs 0.
- **ADD signed overflow:** `W=32`, ADD, `iSign=1`, `A=32'h7FFFFFFF`, `B=1` → cycle 1: `S=32'h80000000`, `V=1`, `N=0`, `Z=0`.
- **SUB unsigned borrow:** SUB, `iSign=0`, `A=3`, `B=5` → `S=32'hFFFFFFFE`, `V=1`, `N=0`.
- **Signed MUL/MULH:** MUL, `iSign=1`, `A=-3`, `B=7` → `oValid` exactly at cycle 33, `S=32'hFFFFFFEB`, `N=1`; `oReady=0` in cycles 1..32. MULH with the same operands → `S=32'hFFFFFFFF`.
- **DIV/REM corner cases:**
  - DIV, `iSign=1`, `A=-7`, `B=2` → `S=-3`.
  - REM with the same operands → `S=-1`.
  - DIV, `B=0`, `A=9` → `S=32'hFFFFFFFF`, `V=1`.
  - DIV, `A=32'h80000000`, `B=-1` → `S=32'h80000000`, `V=1`.
- **Flush and reset abort:**
  - Start DIV, assert `iFlush` at cycle 10 → no `oValid`, `oReady=1` at cycle 11, previous `oS` unchanged.
  - Same sequence with `iRst` at cycle 10 → all outputs 0 and no `oValid`.
